game_arena: RTL and testbench

Parametrised successor of the single-player counter game: a WIDTH-bit up/down counter driven by a 2-bit mode command, with synchronous edge-detected scoring of "loser" (count hits zero) and "winner" (count hits all-ones) events, a configurable winning score, and a GAMEOVER state held until acknowledged. Sits between the player-input logic and the score/display logic; all state is synchronous to one clock.

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_arena_if.sv | 31 +++
 rtl/game_counter.sv | 57 +++++
 rtl/game_arena.sv | 116 +++++++++++
 tb/tb_game_arena.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types for the counter game: player mode command, result owner, FSM states.
package game_pkg;

    typedef enum logic [1:0] {
        UP_1   = 2'd0,
        UP_2   = 2'd1,
        DOWN_1 = 2'd2,
        DOWN_2 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        WHO_NONE   = 2'd0,
        WHO_LOSER  = 2'd1,
        WHO_WINNER = 2'd2
    } who_e;

    typedef enum logic [1:0] {
        INIT_S   = 2'd0,
        ROUND    = 2'd1,
        GAMEOVER = 2'd2
    } state_e;

endpackage

// File: rtl/game_arena_if.sv
// Player-side command inputs and score/display outputs of game_arena.
interface game_arena_if
    import game_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SCORE_W = 4
) ();

    logic               INIT;
    logic [WIDTH-1:0]   val;
    mode_e              CTRL;
    logic               ACK;
    logic [WIDTH-1:0]   count;
    logic               LOSER;
    logic               WINNER;
    logic               GAMEOVER;
    who_e               WHO;
    logic [SCORE_W-1:0] loser_score;
    logic [SCORE_W-1:0] winner_score;

    modport master (
        output INIT, val, CTRL, ACK,
        input  count, LOSER, WINNER, GAMEOVER, WHO, loser_score, winner_score
    );

    modport slave (
        input  INIT, val, CTRL, ACK,
        output count, LOSER, WINNER, GAMEOVER, WHO, loser_score, winner_score
    );

endinterface

// File: rtl/game_counter.sv
// WIDTH-bit load/step counter; load beats step. GAME_SATURATE_EN clamps at 0 / all-ones
// instead of wrapping.
module game_counter
    import game_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] val,
    input  mode_e            ctrl,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] stepped;
    logic             up;

    always_comb begin
        step = (ctrl == UP_2 || ctrl == DOWN_2) ? WIDTH'(2) : WIDTH'(1);
        up   = (ctrl == UP_1 || ctrl == UP_2);
`ifdef GAME_SATURATE_EN
        stepped = '0;
        if (up) begin
            stepped = (count_q > ('1 - step)) ? '1 : count_q + step;
        end else begin
            stepped = (count_q < step) ? '0 : count_q - step;
        end
`else
        stepped = up ? count_q + step : count_q - step;
`endif
    end

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = load ? val : stepped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/game_arena.sv
// Counter game top: round FSM, loser/winner edge scoring and GAMEOVER hold until ACK.
// Optional GAME_SATURATE_EN (in game_counter) selects clamping instead of wrap.
module game_arena
    import game_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int WIN_SCORE = 15,
    parameter int SCORE_W   = $clog2(WIN_SCORE + 1)
) (
    input logic         clk,
    input logic         rst,
    game_arena_if.slave bus
);

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    who_e               who_q, who_d;
    logic [SCORE_W-1:0] loser_score_q, loser_score_d;
    logic [SCORE_W-1:0] winner_score_q, winner_score_d;
    logic               prev_loser_q, prev_loser_d;
    logic               prev_winner_q, prev_winner_d;
    logic               clear;
    logic [WIDTH-1:0]   count;
    logic               loser, winner;
    logic               loser_ev, winner_ev;

    game_counter #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .en    (state_q == ROUND),
        .load  (bus.INIT),
        .val   (bus.val),
        .ctrl  (bus.CTRL),
        .count (count)
    );

    assign loser     = (count == '0);
    assign winner    = (count == '1);
    assign loser_ev  = loser & ~prev_loser_q;
    assign winner_ev = winner & ~prev_winner_q;

    always_comb begin
        state_d        = state_q;
        who_d          = who_q;
        loser_score_d  = loser_score_q;
        winner_score_d = winner_score_q;
        prev_loser_d   = loser;
        prev_winner_d  = winner;
        clear          = 1'b0;
        case (state_q)
            INIT_S: begin
                clear   = 1'b1;
                state_d = ROUND;
            end
            ROUND: begin
                if (loser_ev) begin
                    loser_score_d = loser_score_q + 1'b1;
                    if (loser_score_d == WIN_VAL) begin
                        state_d = GAMEOVER;
                        who_d   = WHO_LOSER;
                    end
                end else if (winner_ev) begin
                    winner_score_d = winner_score_q + 1'b1;
                    if (winner_score_d == WIN_VAL) begin
                        state_d = GAMEOVER;
                        who_d   = WHO_WINNER;
                    end
                end
            end
            GAMEOVER: begin
                if (bus.ACK) begin
                    clear   = 1'b1;
                    state_d = INIT_S;
                end
            end
            default: state_d = INIT_S;
        endcase
        // Leaving GAMEOVER lands in INIT_S already showing reset-like outputs.
        if (clear) begin
            who_d          = WHO_NONE;
            loser_score_d  = '0;
            winner_score_d = '0;
            prev_loser_d   = 1'b1;
            prev_winner_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= INIT_S;
            who_q          <= WHO_NONE;
            loser_score_q  <= '0;
            winner_score_q <= '0;
            prev_loser_q   <= 1'b1;
            prev_winner_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            who_q          <= who_d;
            loser_score_q  <= loser_score_d;
            winner_score_q <= winner_score_d;
            prev_loser_q   <= prev_loser_d;
            prev_winner_q  <= prev_winner_d;
        end
    end

    assign bus.count        = count;
    assign bus.LOSER        = loser;
    assign bus.WINNER       = winner;
    assign bus.GAMEOVER     = (state_q == GAMEOVER);
    assign bus.WHO          = who_q;
    assign bus.loser_score  = loser_score_q;
    assign bus.winner_score = winner_score_q;

endmodule

// File: tb/tb_game_arena.sv
// Directed bench for game_arena with WIDTH=3, WIN_SCORE=2; expectations follow GAME_SATURATE_EN.
module tb_game_arena;
    import game_pkg::*;

    localparam int WIDTH     = 3;
    localparam int WIN_SCORE = 2;
    localparam int SCORE_W   = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    game_arena_if #(.WIDTH(WIDTH), .SCORE_W(SCORE_W)) ifc ();

    game_arena #(.WIDTH(WIDTH), .WIN_SCORE(WIN_SCORE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(ifc.count), 0);
        chk({tag, "_loser"}, 32'(ifc.LOSER), 1);
        chk({tag, "_winner"}, 32'(ifc.WINNER), 0);
        chk({tag, "_gameover"}, 32'(ifc.GAMEOVER), 0);
        chk({tag, "_who"}, 32'(ifc.WHO), 32'(WHO_NONE));
        chk({tag, "_lscore"}, 32'(ifc.loser_score), 0);
        chk({tag, "_wscore"}, 32'(ifc.winner_score), 0);
    endtask

    initial begin
        int   exp_up2;
        int   exp_dn2;
        int   exp_ls;
        int   exp_ws;
        who_e exp_who;
`ifdef GAME_SATURATE_EN
        exp_up2 = 7;
        exp_dn2 = 0;
        exp_ls  = 1;
        exp_ws  = 2;
        exp_who = WHO_WINNER;
`else
        exp_up2 = 0;
        exp_dn2 = 7;
        exp_ls  = 2;
        exp_ws  = 1;
        exp_who = WHO_LOSER;
`endif
        rst      = 1'b1;
        ifc.INIT = 1'b0;
        ifc.val  = '0;
        ifc.CTRL = UP_1;
        ifc.ACK  = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");

        rst = 1'b0;
        tick();
        chk("entry_count", 32'(ifc.count), 0);
        chk("entry_lscore", 32'(ifc.loser_score), 0);

        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("up1_count_%0d", i), 32'(ifc.count), 32'(i));
        end
        chk("winner_before", 32'(ifc.winner_score), 0);
        chk("lscore_no_entry", 32'(ifc.loser_score), 0);

        ifc.INIT = 1'b1;
        ifc.val  = 3'd7;
        tick();
        chk("winner_after", 32'(ifc.winner_score), 1);
        chk("hold7_count", 32'(ifc.count), 7);
        tick();
        chk("hold7_once", 32'(ifc.winner_score), 1);

        ifc.val = 3'd5;
        tick();
        chk("load5", 32'(ifc.count), 5);
        ifc.val = 3'd0;
        tick();
        chk("load0_lscore", 32'(ifc.loser_score), 0);
        tick();
        chk("load0_event", 32'(ifc.loser_score), 1);
        tick();
        chk("load0_once", 32'(ifc.loser_score), 1);

        ifc.val = 3'd6;
        tick();
        chk("load6", 32'(ifc.count), 6);
        ifc.INIT = 1'b0;
        ifc.CTRL = UP_2;
        tick();
        chk("up2_from6", 32'(ifc.count), 32'(exp_up2));
        chk("up2_not_over", 32'(ifc.GAMEOVER), 0);

        ifc.INIT = 1'b1;
        ifc.val  = 3'd3;
        tick();
        chk("over_flag", 32'(ifc.GAMEOVER), 1);
        chk("over_who", 32'(ifc.WHO), 32'(exp_who));
        chk("over_lscore", 32'(ifc.loser_score), 32'(exp_ls));
        chk("over_wscore", 32'(ifc.winner_score), 32'(exp_ws));
        chk("over_count", 32'(ifc.count), 3);

        for (int i = 0; i < 5; i++) begin
            ifc.INIT = i[0];
            ifc.val  = 3'd5;
            ifc.CTRL = DOWN_1;
            tick();
            chk($sformatf("frozen_count_%0d", i), 32'(ifc.count), 3);
            chk($sformatf("frozen_over_%0d", i), 32'(ifc.GAMEOVER), 1);
            chk($sformatf("frozen_lscore_%0d", i), 32'(ifc.loser_score), 32'(exp_ls));
        end

        ifc.INIT = 1'b0;
        ifc.CTRL = UP_1;
        ifc.ACK  = 1'b1;
        tick();
        chk_reset_vals("ack");
        ifc.ACK = 1'b0;
        tick();
        chk("reentry_count", 32'(ifc.count), 0);
        tick();
        chk("reentry_up1", 32'(ifc.count), 1);
        chk("reentry_lscore", 32'(ifc.loser_score), 0);

        ifc.INIT = 1'b1;
        ifc.val  = 3'd0;
        tick();
        tick();
        chk("mid_lscore", 32'(ifc.loser_score), 1);

        ifc.INIT = 1'b0;
        rst      = 1'b1;
        tick();
        chk_reset_vals("midrst");

        rst = 1'b0;
        tick();
        ifc.INIT = 1'b1;
        ifc.val  = 3'd1;
        tick();
        chk("load1", 32'(ifc.count), 1);
        ifc.INIT = 1'b0;
        ifc.CTRL = DOWN_2;
        tick();
        chk("dn2_from1", 32'(ifc.count), 32'(exp_dn2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
